// File: rtl/pu_obuf_ld_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : pu_obuf_ld_stream_if
//  Description : Bundles the load-request, OBUF read-port and SIMD stream
//                signals of pu_obuf_ld_stream. The slave modport is the
//                block's own view; the master modport is the surroundings.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pu_obuf_ld_stream_if #(
    parameter int OBUF_AXI_DATA_WIDTH = 256,
    parameter int SIMD_INTERIM_WIDTH  = 512,
    parameter int ADDR_WIDTH          = 8
);
    // Address-generator side
    logic                           mem_req;
    logic [ADDR_WIDTH-1:0]          mem_addr;
    logic                           mem_ready;
    logic                           obuf_ld_stream_write_ready;
    // OBUF read port
    logic                           arb_grant;
    logic                           buf_read_req;
    logic [ADDR_WIDTH-1:0]          buf_read_addr;
    logic [OBUF_AXI_DATA_WIDTH-1:0] buf_read_data;
    // SIMD stream
    logic [SIMD_INTERIM_WIDTH-1:0]  stream_data;
    logic                           stream_valid;
    logic                           stream_ready;
    // Status
    logic                           lane_err;
    logic                           busy;

    modport slave (
        input  mem_req, mem_addr, arb_grant, buf_read_data, stream_ready,
        output mem_ready, obuf_ld_stream_write_ready, buf_read_req,
               buf_read_addr, stream_data, stream_valid, lane_err, busy
    );

    modport master (
        output mem_req, mem_addr, arb_grant, buf_read_data, stream_ready,
        input  mem_ready, obuf_ld_stream_write_ready, buf_read_req,
               buf_read_addr, stream_data, stream_valid, lane_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/pu_obuf_ld_stream.sv
`default_nettype none
// ============================================================================
//  Module      : pu_obuf_ld_stream
//  Description : Reads NUM_FIFO consecutive OBUF beats, packs them into one
//                SIMD-wide word and queues the words in a small FIFO toward
//                the SIMD unit. A FIFO slot is reserved when beat 0 of a
//                word is accepted, so a started word always has room.
//  Options     : PU_OBUF_LD_STALL_CNT_EN adds a 32-bit saturating count of
//                cycles where a request was presented but not accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module pu_obuf_ld_stream #(
    parameter int OBUF_AXI_DATA_WIDTH = 256,
    parameter int SIMD_INTERIM_WIDTH  = 512,
    parameter int NUM_FIFO            = SIMD_INTERIM_WIDTH / OBUF_AXI_DATA_WIDTH,
    parameter int ADDR_WIDTH          = 8,
    parameter int FIFO_DEPTH          = 4
) (
    input  wire                  clk,
    input  wire                  reset,
`ifdef PU_OBUF_LD_STALL_CNT_EN
    output logic [31:0]          stall_cnt,
`endif
    pu_obuf_ld_stream_if.slave   bus
);

    localparam int c_BEAT_W = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = 1;
    localparam logic [c_CNT_W:0]   c_DEPTH_SUM = (c_CNT_W + 1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0]         w_addr;
    logic                          w_accept;
    logic                          w_write_ready;
    logic                          w_acc_first;
    logic                          w_partial;
    logic                          w_push;
    logic                          w_pop;
    logic                          w_lane_err;
    logic [SIMD_INTERIM_WIDTH-1:0] w_word;
    logic [c_CNT_W:0]              w_slots;

    logic                          r_rd_valid;
    logic [c_CNT_W-1:0]            r_count;
    logic [c_CNT_W-1:0]            r_reserved;
    logic [c_PTR_W-1:0]            r_wr_ptr;
    logic [c_PTR_W-1:0]            r_rd_ptr;
    logic [SIMD_INTERIM_WIDTH-1:0] r_mem [FIFO_DEPTH];

    assign w_addr  = bus.mem_addr;
    assign w_slots = {1'b0, r_count} + {1'b0, r_reserved};

    // Mid-word beats never block: their slot was reserved by beat 0.
    assign w_write_ready = !w_acc_first || (w_slots < c_DEPTH_SUM);
    assign w_accept      = bus.mem_req && bus.arb_grant && w_write_ready && !reset;
    assign w_pop         = (r_count != '0) && bus.stream_ready;

    assign bus.mem_ready                  = bus.arb_grant;
    assign bus.obuf_ld_stream_write_ready = w_write_ready;
    assign bus.buf_read_req               = w_accept;
    assign bus.buf_read_addr              = w_addr;
    assign bus.stream_valid               = (r_count != '0);
    assign bus.stream_data                = r_mem[r_rd_ptr];
    assign bus.lane_err                   = w_lane_err;
    assign bus.busy                       = w_partial || r_rd_valid || (r_count != '0);

    // OBUF returns data one cycle after the strobe; track it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_accept;
        end
    end

    // Slot reservation: claimed by beat 0 of a word, released when it is pushed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reserved <= '0;
        end else begin
            case ({w_accept && w_acc_first, w_push})
                2'b10:   r_reserved <= r_reserved + c_CNT_ONE;
                2'b01:   r_reserved <= r_reserved - c_CNT_ONE;
                default: r_reserved <= r_reserved;
            endcase
        end
    end

    // Word FIFO: storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    generate
        if (NUM_FIFO > 1) begin : g_pack
            localparam logic [c_BEAT_W-1:0] c_BEAT_ONE  = 1;
            localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(NUM_FIFO - 1);

            logic [c_BEAT_W-1:0]                        r_acc_beat;
            logic [c_BEAT_W-1:0]                        r_pk_beat;
            logic                                       r_lane_err;
            logic [(NUM_FIFO-1)*OBUF_AXI_DATA_WIDTH-1:0] r_pack;

            // Accept-side beat position and sticky lane-order check.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_acc_beat <= '0;
                    r_lane_err <= 1'b0;
                end else if (w_accept) begin
                    r_acc_beat <= r_acc_beat + c_BEAT_ONE;
                    if (w_addr[c_BEAT_W-1:0] != r_acc_beat) begin
                        r_lane_err <= 1'b1;
                    end
                end
            end

            // Packer: returned beats fill lanes in arrival order; the last
            // lane bypasses the register straight into the FIFO.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_pk_beat <= '0;
                    r_pack    <= '0;
                end else if (r_rd_valid) begin
                    r_pk_beat <= r_pk_beat + c_BEAT_ONE;
                    for (int i = 0; i < NUM_FIFO - 1; i++) begin
                        if (r_pk_beat == c_BEAT_W'(i)) begin
                            r_pack[i*OBUF_AXI_DATA_WIDTH +: OBUF_AXI_DATA_WIDTH] <= bus.buf_read_data;
                        end
                    end
                end
            end

            assign w_acc_first = (r_acc_beat == '0);
            assign w_partial   = (r_acc_beat != '0) || (r_pk_beat != '0);
            assign w_push      = r_rd_valid && (r_pk_beat == c_BEAT_LAST);
            assign w_word      = {bus.buf_read_data, r_pack};
            assign w_lane_err  = r_lane_err;
        end else begin : g_direct
            assign w_acc_first = 1'b1;
            assign w_partial   = 1'b0;
            assign w_push      = r_rd_valid;
            assign w_word      = bus.buf_read_data;
            assign w_lane_err  = 1'b0;
        end
    endgenerate

`ifdef PU_OBUF_LD_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of cycles where a request was refused.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (bus.mem_req && !w_accept && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pu_obuf_ld_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pu_obuf_ld_stream
//  Description : Self-checking bench for pu_obuf_ld_stream (default sizes:
//                two 256-bit beats per 512-bit word, four-word FIFO).
//                Directed scenarios followed by a randomized run, all
//                checked against a word/slot-level reference model.
//  Options     : PU_OBUF_LD_STALL_CNT_EN also checks stall_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pu_obuf_ld_stream;

    localparam int NF    = 2;
    localparam int DEPTH = 4;
    localparam int W     = 256;

    logic clk;
    logic reset;
`ifdef PU_OBUF_LD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    pu_obuf_ld_stream_if bus ();

    pu_obuf_ld_stream dut (
        .clk       (clk),
        .reset     (reset),
`ifdef PU_OBUF_LD_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // OBUF contents and read port: data appears one cycle after the strobe,
    // garbage otherwise.
    logic [W-1:0] obuf [256];
    always @(posedge clk) begin
        if (bus.buf_read_req) bus.buf_read_data <= obuf[bus.buf_read_addr];
        else                  bus.buf_read_data <= {8{$urandom}};
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: words started but not popped occupy a slot; a word
    // becomes visible two cycles after its last beat is accepted.
    int              cyc     = 0;
    int              m_beat  = 0;
    int              m_slots = 0;
    logic            m_lerr  = 1'b0;
    logic [31:0]     m_stall = 32'd0;
    logic [NF*W-1:0] m_cur   = '0;
    logic [NF*W-1:0] m_q [$];
    int              m_vis [$];
    int              n_rdreq = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [NF*W-1:0] obs, input logic [NF*W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_beat  = 0;
        m_slots = 0;
        m_lerr  = 1'b0;
        m_stall = 32'd0;
        m_cur   = '0;
        m_q.delete();
        m_vis.delete();
        n_rdreq = 0;
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model.
    task automatic cycle(input logic req, input logic [7:0] addr, input logic grant, input logic sready);
        logic exp_ready;
        logic exp_acc;
        logic exp_valid;
        bus.mem_req      = req;
        bus.mem_addr     = addr;
        bus.arb_grant    = grant;
        bus.stream_ready = sready;
        @(negedge clk);
        exp_ready = (m_beat != 0) || (m_slots < DEPTH);
        exp_acc   = req && grant && exp_ready;
        exp_valid = (m_q.size() != 0) && (m_vis[0] <= cyc);
        chk1("mem_ready",    bus.mem_ready, grant);
        chk1("write_ready",  bus.obuf_ld_stream_write_ready, exp_ready);
        chk1("buf_read_req", bus.buf_read_req, exp_acc);
        if (exp_acc) chkw("buf_read_addr", (NF*W)'(bus.buf_read_addr), (NF*W)'(addr));
        chk1("stream_valid", bus.stream_valid, exp_valid);
        if (exp_valid) chkw("stream_data", bus.stream_data, m_q[0]);
        chk1("lane_err",     bus.lane_err, m_lerr);
        chk1("busy",         bus.busy, m_slots != 0);
`ifdef PU_OBUF_LD_STALL_CNT_EN
        chkw("stall_cnt", (NF*W)'(stall_cnt), (NF*W)'(m_stall));
`endif
        if (bus.buf_read_req) n_rdreq++;
        @(posedge clk);
        if (exp_acc) begin
            m_cur[m_beat*W +: W] = obuf[addr];
            if (int'(addr[0]) != m_beat) m_lerr = 1'b1;
            if (m_beat == 0) m_slots++;
            m_beat++;
            if (m_beat == NF) begin
                m_q.push_back(m_cur);
                m_vis.push_back(cyc + 2);
                m_beat = 0;
            end
        end else if (req && m_stall != 32'hFFFF_FFFF) begin
            m_stall++;
        end
        if (exp_valid && sready) begin
            void'(m_q.pop_front());
            void'(m_vis.pop_front());
            m_slots--;
        end
        cyc++;
        #1;
    endtask

    // Reset with a live request presented: outputs must stay quiet.
    task automatic do_reset();
        bus.mem_req      = 1'b1;
        bus.mem_addr     = 8'h00;
        bus.arb_grant    = 1'b1;
        bus.stream_ready = 1'b1;
        reset            = 1'b1;
        @(negedge clk);
        chk1("rst_stream_valid", bus.stream_valid, 1'b0);
        chk1("rst_busy",         bus.busy, 1'b0);
        chk1("rst_buf_read_req", bus.buf_read_req, 1'b0);
        chkw("rst_stream_data",  bus.stream_data, '0);
        chk1("rst_lane_err",     bus.lane_err, 1'b0);
`ifdef PU_OBUF_LD_STALL_CNT_EN
        chkw("rst_stall_cnt", (NF*W)'(stall_cnt), '0);
`endif
        bus.mem_req = 1'b0;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
    endtask

    initial begin
        logic [7:0] a;
        for (int i = 0; i < 256; i++) begin
            obuf[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        end
        reset            = 1'b1;
        bus.mem_req      = 1'b0;
        bus.mem_addr     = 8'h00;
        bus.arb_grant    = 1'b0;
        bus.stream_ready = 1'b0;
        bus.buf_read_data = '0;
        #3;
        do_reset();

        // Two beats pack into one word {B,A}, visible two cycles later.
        cycle(1'b1, 8'h10, 1'b1, 1'b0);
        cycle(1'b1, 8'h11, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk1("pair_valid", bus.stream_valid, 1'b1);
        chkw("pair_word",  bus.stream_data, {obuf[8'h11], obuf[8'h10]});
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1);

        // Back-pressure: only four words' worth of beats get through.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b1, 1'b0);
        chkw("full_rdreq_cnt", (NF*W)'(n_rdreq), (NF*W)'(8));
        chk1("full_wr_ready",  bus.obuf_ld_stream_write_ready, 1'b0);

        // Pop concurrent with the last-beat push of a new word; order kept.
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b1, 8'h30, 1'b1, 1'b0);
        cycle(1'b1, 8'h31, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1);
        chk1("drained_valid", bus.stream_valid, 1'b0);

        // No grant: requests stall and nothing is read.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h40, 1'b0, 1'b0);
        chkw("nogrant_rdreq", (NF*W)'(n_rdreq), '0);
`ifdef PU_OBUF_LD_STALL_CNT_EN
        chkw("nogrant_stall", (NF*W)'(stall_cnt), (NF*W)'(3));
`endif

        // Wrong lane on beat 0 sets a sticky error.
        do_reset();
        cycle(1'b1, 8'h21, 1'b1, 1'b0);
        cycle(1'b1, 8'h21, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1);
        chk1("lane_err_held", bus.lane_err, 1'b1);

        // Reset with half a word outstanding discards it.
        do_reset();
        cycle(1'b1, 8'h50, 1'b1, 1'b0);
        do_reset();
        cycle(1'b1, 8'h60, 1'b1, 1'b0);
        cycle(1'b1, 8'h61, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chkw("post_reset_word", bus.stream_data, {obuf[8'h61], obuf[8'h60]});
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1);

        // Randomized traffic with occasional lane errors and a mid-run reset.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            a    = 8'($urandom);
            a[0] = m_beat[0] ^ ($urandom_range(0, 40) == 0);
            cycle($urandom_range(0, 3) != 0, a, $urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pu_obuf_ld_stream.md
PU_OBUF_LD_STREAM -- requirements
Module: pu_obuf_ld_stream

Interface
REQ-001 SHALL have parameter OBUF_AXI_DATA_WIDTH, default 256: width of one OBUF read beat.
REQ-002 SHALL have parameter SIMD_INTERIM_WIDTH, default 512: width of one packed stream word.
REQ-003 SHALL have parameter NUM_FIFO, default SIMD_INTERIM_WIDTH/OBUF_AXI_DATA_WIDTH: beats per word, a power of two, at least 1.
REQ-004 SHALL have parameter ADDR_WIDTH, default 8: OBUF beat-address width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: stream FIFO entries, a power of two, at least 2.
REQ-006 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-008 SHALL have port mem_req, input, 1 bit: load beat request from the address generator.
REQ-009 SHALL have port mem_addr, input, ADDR_WIDTH bits: beat address; low log2(NUM_FIFO) bits are the lane.
REQ-010 SHALL have port mem_ready, output, 1 bit: OBUF read port available.
REQ-011 SHALL have port obuf_ld_stream_write_ready, output, 1 bit: stream has room for the beat.
REQ-012 SHALL have port arb_grant, input, 1 bit: OBUF arbiter grants the read port to this block.
REQ-013 SHALL have port buf_read_req, output, 1 bit: OBUF read strobe.
REQ-014 SHALL have port buf_read_addr, output, ADDR_WIDTH bits: OBUF read address.
REQ-015 SHALL have port buf_read_data, input, OBUF_AXI_DATA_WIDTH bits: valid exactly 1 cycle after buf_read_req.
REQ-016 SHALL have port stream_data, output, SIMD_INTERIM_WIDTH bits: FIFO head word.
REQ-017 SHALL have ports stream_valid (output, 1 bit) and stream_ready (input, 1 bit): valid/ready handshake toward SIMD.
REQ-018 SHALL have port lane_err, output, 1 bit: sticky lane-order error flag.
REQ-019 SHALL have port busy, output, 1 bit: partial word, read in flight, or FIFO not empty.

Function
REQ-020 SHALL accept a beat when mem_req && mem_ready && obuf_ld_stream_write_ready, all in the same cycle.
REQ-021 SHALL drive mem_ready = arb_grant, buf_read_req = accept, and buf_read_addr = mem_addr, all combinationally with zero latency.
REQ-022 SHALL keep accept-side beat counter acc_beat (0..NUM_FIFO-1), incrementing on accept and wrapping to 0 after NUM_FIFO-1.
REQ-023 SHALL hold obuf_ld_stream_write_ready high when acc_beat != 0; otherwise high only when count + reserved < FIFO_DEPTH. count is the number of FIFO entries. reserved is the number of words whose beat 0 was accepted but whose word is not yet pushed.
REQ-024 SHALL increment reserved on an accept with acc_beat == 0 and decrement it on push; both in one cycle leave it unchanged.
REQ-025 SHALL register read-valid one cycle after accept and write buf_read_data into the packer at lane pk_beat, bits [pk_beat*OBUF_AXI_DATA_WIDTH +: OBUF_AXI_DATA_WIDTH].
REQ-026 SHALL push the packed word, including the current beat, into the FIFO on the cycle the last lane is written; end-to-end latency is 2 cycles from the last accept to stream_valid with the FIFO empty.
REQ-027 SHALL pop on stream_valid && stream_ready; simultaneous push and pop leave count unchanged; the FIFO never overflows and never underflows.
REQ-028 SHALL drive stream_valid = (count != 0) and stream_data from the FIFO head, registered.
REQ-029 SHALL set lane_err, and hold it until reset, on an accept whose mem_addr lane bits differ from acc_beat; the beat is still packed at acc_beat.
REQ-030 SHALL, when NUM_FIFO == 1, omit the packer; each beat is one word and lane_err stays 0.

Reset
REQ-031 SHALL asynchronously clear on reset: acc_beat, pk_beat, reserved, count, FIFO pointers, read-valid, lane_err, and the packer register.
REQ-032 SHALL hold these output values during reset: stream_valid=0, busy=0, buf_read_req=0 (forced low), stream_data=0, lane_err=0.
REQ-033 SHALL discard any partial word or in-flight read present when reset asserts mid-operation.

Configuration
REQ-034 SHALL, when macro PU_OBUF_LD_STALL_CNT_EN is defined, add output stall_cnt (32 bits).
- stall_cnt increments each cycle mem_req is high and the beat is not accepted.
- It saturates at all-ones and is cleared by reset.
REQ-035 SHALL, without PU_OBUF_LD_STALL_CNT_EN, have no stall_cnt port and no counter logic.

Verification
REQ-036 SHALL cover: NUM_FIFO=2, arb_grant=1, addrs 0x10,0x11 with data A,B -> one word {B,A}, stream_valid 2 cycles after 0x11 accept.
REQ-037 SHALL cover: stream_ready=0, 8 beats issued -> 4 words stored, obuf_ld_stream_write_ready=0 at acc_beat=0, no 9th buf_read_req.
REQ-038 SHALL cover: FIFO full, one pop concurrent with a last-beat push -> count stays 4, no data lost, order preserved.
REQ-039 SHALL cover: arb_grant=0 for 3 cycles with mem_req=1 -> mem_ready=0, no buf_read_req, stall_cnt=3 with PU_OBUF_LD_STALL_CNT_EN.
REQ-040 SHALL cover: addr 0x21 accepted at acc_beat=0 -> lane_err=1 next cycle, held until reset.
REQ-041 SHALL cover: reset asserted after beat 0 only -> stream_valid=0, busy=0, next word packs from lane 0.
